uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_sync.sv | 22 ++
 rtl/uart_rx.sv | 131 +++++++++++++
 tb/tb_uart_rx.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and bit-timing constants shared by uart_rx and uart_tx.
// Pure declarations: no latency and no backpressure.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam int BIT_CYCLES   = 27;
  localparam int SAMPLE_POINT = 13;
  localparam int CNT_W        = $clog2(BIT_CYCLES);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_POINT);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(BIT_CYCLES - 1);

  // Expected parity: 0 = even, 1 = odd; returns 1 when the received bit disagrees.
  function automatic logic parity_mismatch(input logic [7:0] data,
                                           input logic       par,
                                           input logic       ptype);
    return ((^data) ^ par) != ptype;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the asynchronous rx line, resets to idle-high.
// Latency 2 clk_3125 cycles; no backpressure.
module uart_rx_sync (
  input  logic clk_3125,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_3125) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: start/8 data MSB-first/parity/stop receiver, 27 clocks per bit; UART_RX_PARITY_CHK_EN enables parity_err.
// rx_complete pulses ~3 cycles after the stop bit ends; no backpressure, each byte is a single-cycle pulse.
module uart_rx
  import uart_pkg::*;
(
  input  logic       clk_3125,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       parity_type,
  output logic [7:0] rx_msg,
  output logic       rx_parity,
  output logic       rx_complete,
  output logic       parity_err
);

  logic             rx_s;
  uart_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       sh;
  logic             par_bit;
  logic             armed;

  uart_rx_sync u_sync (
    .clk_3125 (clk_3125),
    .rst_n    (rst_n),
    .d        (rx),
    .q        (rx_s)
  );

  always_ff @(posedge clk_3125) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      sh          <= '0;
      par_bit     <= 1'b0;
      armed       <= 1'b0;
      rx_msg      <= '0;
      rx_parity   <= 1'b0;
      rx_complete <= 1'b0;
`ifdef UART_RX_PARITY_CHK_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      rx_complete <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          // The detection cycle counts as tick 0 of the start bit, so START begins at 1.
          if (armed && !rx_s) begin
            state   <= START;
            cnt     <= CNT_ONE;
            bit_idx <= '0;
            armed   <= 1'b0;
          end else if (rx_s) begin
            armed <= 1'b1;
          end
        end

        START: begin
          if (cnt == CNT_SAMPLE && rx_s) begin
            state <= IDLE;
            cnt   <= '0;
            armed <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state <= DATA;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == CNT_SAMPLE) sh <= {sh[6:0], rx_s};
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= PARITY;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        PARITY: begin
          if (cnt == CNT_SAMPLE) par_bit <= rx_s;
          if (cnt == CNT_LAST) begin
            state <= STOP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          // A low stop bit is a framing error: drop the byte and wait for the line to idle.
          if (cnt == CNT_SAMPLE && !rx_s) begin
            state <= IDLE;
            cnt   <= '0;
            armed <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state       <= IDLE;
            cnt         <= '0;
            armed       <= 1'b1;
            rx_msg      <= sh;
            rx_parity   <= par_bit;
            rx_complete <= 1'b1;
`ifdef UART_RX_PARITY_CHK_EN
            parity_err  <= parity_mismatch(sh, par_bit, parity_type);
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
          armed <= 1'b0;
        end
      endcase
    end
  end

`ifndef UART_RX_PARITY_CHK_EN
  logic unused_parity_type;
  assign unused_parity_type = parity_type;
  assign parity_err         = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into uart_rx with a queue-based scoreboard and an independent monitor.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int BIT = 27;

  logic       clk_3125 = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       parity_type;
  logic [7:0] rx_msg;
  logic       rx_parity;
  logic       rx_complete;
  logic       parity_err;

  typedef struct {
    logic [7:0] msg;
    logic       par;
    logic       perr;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total  = 0;
  int   bad    = 0;
  int   n_done = 0;
  logic prev_cmp = 1'b0;

  uart_rx dut (
    .clk_3125    (clk_3125),
    .rst_n       (rst_n),
    .rx          (rx),
    .parity_type (parity_type),
    .rx_msg      (rx_msg),
    .rx_parity   (rx_parity),
    .rx_complete (rx_complete),
    .parity_err  (parity_err)
  );

  always #160 clk_3125 = ~clk_3125;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every rx_complete pops one expected byte.
  always @(negedge clk_3125) begin
    if (rx_complete) begin
      n_done++;
      if (prev_cmp) check("pulse_one_cycle", 32'(prev_cmp), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_complete", 32'(rx_msg), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("rx_msg", 32'(rx_msg), 32'(e.msg));
        check("rx_parity", 32'(rx_parity), 32'(e.par));
        check("parity_err", 32'(parity_err), 32'(e.perr));
      end
    end
    prev_cmp = rx_complete;
  end

  task automatic push_exp(input logic [7:0] d, input logic p);
    exp_t x;
    x.msg  = d;
    x.par  = p;
`ifdef UART_RX_PARITY_CHK_EN
    x.perr = ((^d) ^ p) != parity_type;
`else
    x.perr = 1'b0;
`endif
    sb.push_back(x);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT) @(negedge clk_3125);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
    send_bit(1'b0);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(p);
    send_bit(stop);
  endtask

  task automatic idle_gap();
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk_3125);
  endtask

  // rx_complete must arrive within 4 cycles of the end of the stop bit.
  task automatic lat_check(input int target);
    for (int i = 0; i < 4; i++) begin
      if (n_done >= target) break;
      @(negedge clk_3125);
      #1;
    end
    check("complete_latency", 32'(n_done >= target), 32'd1);
  endtask

  task automatic send_checked(input logic [7:0] d, input logic p);
    int target;
    target = n_done + 1;
    push_exp(d, p);
    send_frame(d, p, 1'b1);
    lat_check(target);
    idle_gap();
  endtask

  initial begin
    int saved;
    int target;
    rx          = 1'b1;
    rst_n       = 1'b0;
    parity_type = 1'b0;
    repeat (3) @(negedge clk_3125);
    check("reset_rx_msg", 32'(rx_msg), 32'd0);
    check("reset_rx_parity", 32'(rx_parity), 32'd0);
    check("reset_rx_complete", 32'(rx_complete), 32'd0);
    check("reset_parity_err", 32'(parity_err), 32'd0);
    rst_n = 1'b1;
    idle_gap();

    parity_type = 1'b0;
    send_checked(8'h5A, 1'b0);
    send_checked(8'hA7, 1'b1);
    send_checked(8'hA7, 1'b0);
    parity_type = 1'b1;
    send_checked(8'h00, 1'b0);
    send_checked(8'h5A, 1'b1);
    parity_type = 1'b0;

    // Back-to-back frames with no idle time between stop and start.
    target = n_done + 2;
    push_exp(8'h01, 1'b1);
    push_exp(8'hFF, 1'b0);
    send_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    lat_check(target);
    idle_gap();

    // Glitch shorter than half a bit is rejected as a false start.
    saved = n_done;
    rx = 1'b0;
    repeat (8) @(negedge clk_3125);
    idle_gap();
    check("false_start_no_complete", 32'(n_done), 32'(saved));
    check("false_start_msg_hold", 32'(rx_msg), 32'hFF);

    // Framing error: stop bit low.
    send_frame(8'h3C, 1'b0, 1'b0);
    idle_gap();
    check("framing_no_complete", 32'(n_done), 32'(saved));
    check("framing_msg_hold", 32'(rx_msg), 32'hFF);
    send_checked(8'h3C, 1'b0);

    // Reset in the middle of data bit 4.
    saved = n_done;
    send_bit(1'b0);
    for (int i = 7; i >= 4; i--) send_bit(i[0]);
    rx = 1'b1;
    repeat (13) @(negedge clk_3125);
    rst_n = 1'b0;
    @(negedge clk_3125);
    rst_n = 1'b1;
    check("midreset_rx_msg", 32'(rx_msg), 32'd0);
    check("midreset_rx_parity", 32'(rx_parity), 32'd0);
    check("midreset_rx_complete", 32'(rx_complete), 32'd0);
    check("midreset_parity_err", 32'(parity_err), 32'd0);
    idle_gap();
    idle_gap();
    check("midreset_no_complete", 32'(n_done), 32'(saved));
    send_checked(8'h81, 1'b0);

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk_3125);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
